// File: rtl/pc_branch_unit.sv
// Program-counter and branch-redirect stage.
// Holds the fetch PC and asserts the squash pulse on taken control transfers.
// A misaligned control-transfer target raises a sticky trap.
module pc_branch_unit #(
  parameter logic [31:0] RESET_PC     = 32'h0000_0000,
  parameter int unsigned FLUSH_CYCLES = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall,
  input  logic        branch,
  input  logic        b,
  input  logic        jal,
  input  logic        jalr,
  input  logic [31:0] ex_pc,
  input  logic [31:0] imm,
  input  logic [31:0] rs1_d,
  output logic [31:0] pc,
  output logic [31:0] pc_plus4,
  output logic [31:0] link_addr,
  output logic        flush,
  output logic        trap,
  output logic [31:0] trap_pc,
  output logic [15:0] taken_cnt
);

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    FLUSH = 2'd1,
    TRAP  = 2'd2
  } state_t;

  localparam logic [2:0] FLUSH_LOAD = 3'(FLUSH_CYCLES);

  state_t      state, state_nx;
  logic [2:0]  cnt, cnt_nx;
  logic [31:0] pc_nx, trap_pc_nx;
  logic        flush_nx, trap_nx;
  logic [15:0] taken_cnt_nx;

  logic        take;
  logic        misaligned;
  logic [31:0] target;

  assign pc_plus4  = pc + 32'd4;
  assign link_addr = ex_pc + 32'd4;

  // Redirect decision and target; jalr has priority over jal/branch
  always_comb begin
    take = jalr | jal | (branch & b);
    if (jalr) begin
      target = (rs1_d + imm) & ~32'h1;
    end else begin
      target = ex_pc + imm;
    end
    misaligned = (target[1:0] != 2'b00);
  end

  // Next-state and next-output logic
  always_comb begin
    state_nx     = state;
    cnt_nx       = cnt;
    pc_nx        = pc;
    flush_nx     = flush;
    trap_nx      = trap;
    trap_pc_nx   = trap_pc;
    taken_cnt_nx = taken_cnt;
    case (state)
      RUN: begin
        if (!stall) begin
          if (take && !misaligned) begin
            pc_nx    = target;
            flush_nx = 1'b1;
            cnt_nx   = FLUSH_LOAD;
            state_nx = FLUSH;
            if (taken_cnt != '1) begin
              taken_cnt_nx = taken_cnt + 16'd1;
            end
          end else if (take) begin
            trap_nx    = 1'b1;
            trap_pc_nx = ex_pc;
            state_nx   = TRAP;
          end else begin
            pc_nx = pc + 32'd4;
          end
        end
      end
      FLUSH: begin
        // Control inputs belong to squashed instructions here and are ignored
        if (!stall) begin
          pc_nx  = pc + 32'd4;
          cnt_nx = cnt - 3'd1;
          if (cnt <= 3'd1) begin
            cnt_nx   = '0;
            flush_nx = 1'b0;
            state_nx = RUN;
          end
        end
      end
      TRAP: begin
        flush_nx = 1'b0;
        trap_nx  = 1'b1;
      end
      default: begin
        state_nx = RUN;
        flush_nx = 1'b0;
        cnt_nx   = '0;
      end
    endcase
  end

  // State register; reset overrides stall and the trap state
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= RUN;
      cnt       <= '0;
      pc        <= RESET_PC;
      flush     <= 1'b0;
      trap      <= 1'b0;
      trap_pc   <= '0;
      taken_cnt <= '0;
    end else begin
      state     <= state_nx;
      cnt       <= cnt_nx;
      pc        <= pc_nx;
      flush     <= flush_nx;
      trap      <= trap_nx;
      trap_pc   <= trap_pc_nx;
      taken_cnt <= taken_cnt_nx;
    end
  end

endmodule

// File: tb/tb_pc_branch_unit.sv
// Directed bench for pc_branch_unit: vector table plus hand sequences.
module tb_pc_branch_unit;

  logic        clk = 1'b0;
  logic        rst, stall, branch, b, jal, jalr;
  logic [31:0] ex_pc, imm, rs1_d;
  logic [31:0] pc, pc_plus4, link_addr, trap_pc;
  logic        flush, trap;
  logic [15:0] taken_cnt;

  int n_cmp = 0;
  int n_bad = 0;

  pc_branch_unit #(.RESET_PC(32'h0000_0000), .FLUSH_CYCLES(2)) dut (
    .clk(clk), .rst(rst), .stall(stall), .branch(branch), .b(b),
    .jal(jal), .jalr(jalr), .ex_pc(ex_pc), .imm(imm), .rs1_d(rs1_d),
    .pc(pc), .pc_plus4(pc_plus4), .link_addr(link_addr), .flush(flush),
    .trap(trap), .trap_pc(trap_pc), .taken_cnt(taken_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        rst, stall, branch, b, jal, jalr;
    logic [31:0] ex_pc, imm, rs1_d;
    logic [31:0] e_pc;
    logic        e_flush, e_trap;
    logic [31:0] e_trap_pc;
    logic [15:0] e_cnt;
  } vec_t;

  vec_t vt[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic drive(input logic r, input logic s, input logic br, input logic bb,
                       input logic j, input logic jr, input logic [31:0] ep,
                       input logic [31:0] im, input logic [31:0] r1);
    rst = r; stall = s; branch = br; b = bb; jal = j; jalr = jr;
    ex_pc = ep; imm = im; rs1_d = r1;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_state(input string tag, input logic [31:0] e_pc, input logic e_fl,
                           input logic e_tr, input logic [31:0] e_tpc, input logic [15:0] e_cnt);
    chk({tag, ".pc"}, pc, e_pc);
    chk({tag, ".pc_plus4"}, pc_plus4, e_pc + 32'd4);
    chk({tag, ".flush"}, {31'd0, flush}, {31'd0, e_fl});
    chk({tag, ".trap"}, {31'd0, trap}, {31'd0, e_tr});
    chk({tag, ".trap_pc"}, trap_pc, e_tpc);
    chk({tag, ".taken_cnt"}, {16'd0, taken_cnt}, {16'd0, e_cnt});
  endtask

  function automatic vec_t mk(input logic r, input logic s, input logic br, input logic bb,
                              input logic j, input logic jr, input logic [31:0] ep,
                              input logic [31:0] im, input logic [31:0] r1,
                              input logic [31:0] epc, input logic efl, input logic [15:0] ecnt);
    vec_t v;
    v.rst = r; v.stall = s; v.branch = br; v.b = bb; v.jal = j; v.jalr = jr;
    v.ex_pc = ep; v.imm = im; v.rs1_d = r1;
    v.e_pc = epc; v.e_flush = efl; v.e_trap = 1'b0; v.e_trap_pc = 32'd0; v.e_cnt = ecnt;
    return v;
  endfunction

  initial begin
    drive(1'b1, 0, 0, 0, 0, 0, 32'd0, 32'd0, 32'd0);

    //            rst stl br b jal jr ex_pc         imm           rs1          exp_pc        fl cnt
    // reset and sequential fetch
    vt.push_back(mk(1, 0, 0, 0, 0, 0, 32'h0,        32'h0,        32'h0,       32'h0,        0, 0));
    vt.push_back(mk(1, 0, 0, 0, 0, 0, 32'h0,        32'h0,        32'h0,       32'h0,        0, 0));
    vt.push_back(mk(0, 0, 0, 0, 0, 0, 32'h0,        32'h0,        32'h0,       32'h4,        0, 0));
    vt.push_back(mk(0, 0, 0, 0, 0, 0, 32'h0,        32'h0,        32'h0,       32'h8,        0, 0));
    vt.push_back(mk(0, 0, 0, 0, 0, 0, 32'h0,        32'h0,        32'h0,       32'hC,        0, 0));
    vt.push_back(mk(0, 0, 0, 0, 0, 0, 32'h0,        32'h0,        32'h0,       32'h10,       0, 0));
    // taken branch, second branch inside flush is ignored
    vt.push_back(mk(0, 0, 1, 1, 0, 0, 32'h10,       32'h20,       32'h0,       32'h30,       1, 1));
    vt.push_back(mk(0, 0, 1, 1, 0, 0, 32'h100,      32'h40,       32'h0,       32'h34,       1, 1));
    vt.push_back(mk(0, 0, 0, 0, 0, 0, 32'h0,        32'h0,        32'h0,       32'h38,       0, 1));
    // not-taken branch
    vt.push_back(mk(0, 0, 1, 0, 0, 0, 32'h38,       32'h100,      32'h0,       32'h3C,       0, 1));
    // stall in RUN masks a taken branch
    vt.push_back(mk(0, 1, 1, 1, 0, 0, 32'h0,        32'h100,      32'h0,       32'h3C,       0, 1));
    vt.push_back(mk(0, 1, 0, 0, 1, 0, 32'h0,        32'h200,      32'h0,       32'h3C,       0, 1));
    vt.push_back(mk(0, 0, 0, 0, 0, 0, 32'h0,        32'h0,        32'h0,       32'h40,       0, 1));
    // stall inside flush holds pc, flush and the remaining count
    vt.push_back(mk(0, 0, 0, 0, 1, 0, 32'h40,       32'h40,       32'h0,       32'h80,       1, 2));
    vt.push_back(mk(0, 1, 1, 1, 0, 0, 32'h0,        32'h8,        32'h0,       32'h80,       1, 2));
    vt.push_back(mk(0, 1, 0, 0, 1, 0, 32'h0,        32'h8,        32'h0,       32'h80,       1, 2));
    vt.push_back(mk(0, 1, 0, 0, 0, 0, 32'h0,        32'h0,        32'h0,       32'h80,       1, 2));
    vt.push_back(mk(0, 0, 0, 0, 0, 0, 32'h0,        32'h0,        32'h0,       32'h84,       1, 2));
    vt.push_back(mk(0, 1, 0, 0, 0, 0, 32'h0,        32'h0,        32'h0,       32'h84,       1, 2));
    vt.push_back(mk(0, 0, 0, 0, 0, 0, 32'h0,        32'h0,        32'h0,       32'h88,       0, 2));
    // jal+jalr together: jalr wins
    vt.push_back(mk(0, 0, 0, 0, 1, 1, 32'hFFFF_FFF0, 32'h20,      32'h200,     32'h220,      1, 3));
    vt.push_back(mk(0, 0, 0, 0, 0, 0, 32'h0,        32'h0,        32'h0,       32'h224,      1, 3));
    vt.push_back(mk(0, 0, 0, 0, 0, 0, 32'h0,        32'h0,        32'h0,       32'h228,      0, 3));
    // jal target wraps past 2^32
    vt.push_back(mk(0, 0, 0, 0, 1, 0, 32'hFFFF_FFF0, 32'h20,      32'h0,       32'h10,       1, 4));
    vt.push_back(mk(0, 0, 0, 0, 0, 0, 32'h0,        32'h0,        32'h0,       32'h14,       1, 4));
    vt.push_back(mk(0, 0, 0, 0, 0, 0, 32'h0,        32'h0,        32'h0,       32'h18,       0, 4));
    // backward branch with negative immediate
    vt.push_back(mk(0, 0, 1, 1, 0, 0, 32'h100,      32'hFFFF_FFF0, 32'h0,      32'hF0,       1, 5));
    vt.push_back(mk(0, 0, 0, 0, 0, 0, 32'h0,        32'h0,        32'h0,       32'hF4,       1, 5));
    vt.push_back(mk(0, 0, 0, 0, 0, 0, 32'h0,        32'h0,        32'h0,       32'hF8,       0, 5));
    // jalr clears bit 0 of the sum: 0x1001 + 3 = 0x1004
    vt.push_back(mk(0, 0, 0, 0, 0, 1, 32'h200,      32'h3,        32'h1001,    32'h1004,     1, 6));
    vt.push_back(mk(0, 0, 0, 0, 0, 0, 32'h0,        32'h0,        32'h0,       32'h1008,     1, 6));
    vt.push_back(mk(0, 0, 0, 0, 0, 0, 32'h0,        32'h0,        32'h0,       32'h100C,     0, 6));

    foreach (vt[i]) begin
      drive(vt[i].rst, vt[i].stall, vt[i].branch, vt[i].b, vt[i].jal, vt[i].jalr,
            vt[i].ex_pc, vt[i].imm, vt[i].rs1_d);
      #1;
      chk($sformatf("v%0d.link_addr", i), link_addr, vt[i].ex_pc + 32'd4);
      step();
      chk_state($sformatf("v%0d", i), vt[i].e_pc, vt[i].e_flush, vt[i].e_trap,
                vt[i].e_trap_pc, vt[i].e_cnt);
    end

    // Misaligned JAL target 0x46 traps; everything frozen until reset
    drive(0, 0, 0, 0, 1, 0, 32'h40, 32'h6, 32'h0);
    #1;
    chk("trap.link_addr", link_addr, 32'h44);
    step();
    chk_state("trap.enter", 32'h100C, 0, 1, 32'h40, 16'd6);
    for (int k = 0; k < 10; k++) begin
      drive(0, (k % 3) == 2, k[0], 1'b1, k[1], 1'b0, 32'h80 + k * 4, 32'h10, 32'h0);
      step();
      chk_state($sformatf("trap.hold%0d", k), 32'h100C, 0, 1, 32'h40, 16'd6);
    end
    drive(1, 1, 0, 0, 1, 0, 32'h0, 32'h0, 32'h0);
    step();
    chk_state("trap.rst", 32'h0, 0, 0, 32'h0, 16'd0);
    drive(0, 0, 0, 0, 0, 0, 32'h0, 32'h0, 32'h0);
    step();
    chk_state("trap.after", 32'h4, 0, 0, 32'h0, 16'd0);

    // Misaligned jalr target after the bit-0 clear: 0x3 -> 0x2 traps
    drive(0, 0, 0, 0, 0, 1, 32'h500, 32'h0, 32'h3);
    step();
    chk_state("jalr_mis", 32'h4, 0, 1, 32'h500, 16'd0);
    drive(1, 0, 0, 0, 0, 0, 32'h0, 32'h0, 32'h0);
    step();
    chk_state("jalr_mis.rst", 32'h0, 0, 0, 32'h0, 16'd0);

    // Reset in the middle of a flush drops flush on that edge
    drive(0, 0, 1, 1, 0, 0, 32'h0, 32'h40, 32'h0);
    step();
    chk_state("mid.redirect", 32'h40, 1, 0, 32'h0, 16'd1);
    drive(1, 0, 0, 0, 0, 0, 32'h0, 32'h0, 32'h0);
    step();
    chk_state("mid.rst", 32'h0, 0, 0, 32'h0, 16'd0);
    drive(0, 0, 0, 0, 0, 0, 32'h0, 32'h0, 32'h0);
    step();
    chk_state("mid.run", 32'h4, 0, 0, 32'h0, 16'd0);

    // Sequential fetch wraps 0xFFFF_FFFC -> 0
    drive(0, 0, 0, 0, 1, 0, 32'hFFFF_FFF0, 32'hC, 32'h0);
    step();
    chk_state("wrap.redirect", 32'hFFFF_FFFC, 1, 0, 32'h0, 16'd1);
    drive(0, 0, 0, 0, 0, 0, 32'h0, 32'h0, 32'h0);
    step();
    chk_state("wrap.zero", 32'h0, 1, 0, 32'h0, 16'd1);
    step();
    chk_state("wrap.four", 32'h4, 0, 0, 32'h0, 16'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
